// File: rtl/hazard_detect_id.sv
// ID-stage load-use / branch-operand hazard detector. It works out how many bubbles
// the ID instruction needs, sequences multi-cycle stalls and counts stall cycles.
module hazard_detect_id #(
    parameter int REG_FILE_ADDR_LEN = 5,
    parameter int STALL_CNT_LEN     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REG_FILE_ADDR_LEN-1:0] ID_Rs,
    input  logic [REG_FILE_ADDR_LEN-1:0] ID_Rt,
    input  logic                         ID_two_src,
    input  logic                         ID_is_branch,
    input  logic [REG_FILE_ADDR_LEN-1:0] EXE_Dest,
    input  logic [REG_FILE_ADDR_LEN-1:0] MEM_Dest,
    input  logic                         EXE_WB_EN,
    input  logic                         MEM_WB_EN,
    input  logic                         EXE_MEM_R_EN,
    input  logic                         MEM_MEM_R_EN,
    input  logic                         fwd_EN,
    input  logic                         branch_taken,
    input  logic                         mem_stall,
    output logic                         hazard_detected,
    output logic                         ID_EXE_bubble,
    output logic                         IF_ID_flush,
    output logic [STALL_CNT_LEN-1:0]     stall_cycles
);
    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [1:0] rem, rem_nxt;
    logic [1:0] need_n;
    logic       exe_match, mem_match, stall_req;

    // WB-stage producers are never checked: the register file writes before it reads.
    assign exe_match = EXE_WB_EN && (EXE_Dest != '0) &&
                       ((EXE_Dest == ID_Rs) || (ID_two_src && (EXE_Dest == ID_Rt)));
    assign mem_match = MEM_WB_EN && (MEM_Dest != '0) &&
                       ((MEM_Dest == ID_Rs) || (ID_two_src && (MEM_Dest == ID_Rt)));

    always_comb begin
        need_n = 2'd0;
        if (fwd_EN) begin
            if (exe_match && EXE_MEM_R_EN)
                need_n = ID_is_branch ? 2'd2 : 2'd1;
            else if ((exe_match && ID_is_branch) || (mem_match && MEM_MEM_R_EN && ID_is_branch))
                need_n = 2'd1;
        end else begin
            if (exe_match)
                need_n = 2'd2;
            else if (mem_match)
                need_n = 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rem   <= 2'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        if (branch_taken) begin
            state_nxt = IDLE;
            rem_nxt   = 2'd0;
        end else if (!mem_stall) begin
            case (state)
                IDLE: if (need_n == 2'd2) begin
                    state_nxt = STALL;
                    rem_nxt   = 2'd1;
                end
                STALL: begin
                    rem_nxt = rem - 2'd1;
                    if (rem <= 2'd1) begin
                        state_nxt = IDLE;
                        rem_nxt   = 2'd0;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    rem_nxt   = 2'd0;
                end
            endcase
        end
    end

    assign stall_req = ((state == IDLE) && (need_n != 2'd0)) || (state == STALL);

    always_comb begin
        hazard_detected = 1'b0;
        ID_EXE_bubble   = 1'b0;
        IF_ID_flush     = 1'b0;
        if (!rst) begin
            hazard_detected = stall_req && !branch_taken;
            ID_EXE_bubble   = stall_req || branch_taken;
            IF_ID_flush     = branch_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles <= '0;
        else if (hazard_detected && !mem_stall && (stall_cycles != '1))
            stall_cycles <= stall_cycles + 1'b1;
    end
endmodule

// File: tb/tb_hazard_detect_id.sv
// Directed-vector bench: the driver queues hand-computed expectations each cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_detect_id;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_Rs, ID_Rt, EXE_Dest, MEM_Dest;
    logic        ID_two_src, ID_is_branch, EXE_WB_EN, MEM_WB_EN;
    logic        EXE_MEM_R_EN, MEM_MEM_R_EN, fwd_EN, branch_taken, mem_stall;
    logic        hazard_detected, ID_EXE_bubble, IF_ID_flush;
    logic [15:0] stall_cycles;

    typedef struct {
        string       name;
        logic        haz;
        logic        bub;
        logic        fl;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    hazard_detect_id #(.REG_FILE_ADDR_LEN(5), .STALL_CNT_LEN(16)) dut (
        .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_two_src(ID_two_src),
        .ID_is_branch(ID_is_branch), .EXE_Dest(EXE_Dest), .MEM_Dest(MEM_Dest),
        .EXE_WB_EN(EXE_WB_EN), .MEM_WB_EN(MEM_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN),
        .MEM_MEM_R_EN(MEM_MEM_R_EN), .fwd_EN(fwd_EN), .branch_taken(branch_taken),
        .mem_stall(mem_stall), .hazard_detected(hazard_detected),
        .ID_EXE_bubble(ID_EXE_bubble), .IF_ID_flush(IF_ID_flush),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (hazard_detected !== e.haz || ID_EXE_bubble !== e.bub ||
                IF_ID_flush !== e.fl || stall_cycles !== e.cnt) begin
                failures++;
                $display("FAIL %s: got haz=%b bub=%b flush=%b cnt=%h, expected haz=%b bub=%b flush=%b cnt=%h",
                         e.name, hazard_detected, ID_EXE_bubble, IF_ID_flush, stall_cycles,
                         e.haz, e.bub, e.fl, e.cnt);
            end
        end
    end

    task automatic clr();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_two_src = 1'b0; ID_is_branch = 1'b0;
        EXE_Dest = 5'd0; MEM_Dest = 5'd0; EXE_WB_EN = 1'b0; MEM_WB_EN = 1'b0;
        EXE_MEM_R_EN = 1'b0; MEM_MEM_R_EN = 1'b0; fwd_EN = 1'b1;
        branch_taken = 1'b0; mem_stall = 1'b0;
    endtask

    // expectation for the cycle currently being driven, then advance one cycle
    task automatic chk(input string name, input logic h, input logic b, input logic f,
                       input logic [15:0] c);
        exp_t e;
        e.name = name; e.haz = h; e.bub = b; e.fl = f; e.cnt = c;
        q.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic load_branch_4();
        clr();
        EXE_Dest = 5'd4; EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1;
        ID_Rs = 5'd4; ID_Rt = 5'd5; ID_two_src = 1'b1; ID_is_branch = 1'b1;
    endtask

    task automatic load_use_8();
        clr();
        EXE_Dest = 5'd8; EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1;
        ID_Rs = 5'd8; ID_Rt = 5'd3; ID_two_src = 1'b1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        @(posedge clk); #1;
        load_use_8();
        chk("reset_forces_zero", 0, 0, 0, 16'd0);
        rst = 1'b0;

        // load-use with forwarding: one bubble
        load_use_8();
        chk("loaduse_stall", 1, 1, 0, 16'd0);
        clr(); ID_Rs = 5'd9;
        chk("loaduse_advance", 0, 0, 0, 16'd1);

        // load then branch: two bubbles, then ALU producer then branch: one
        load_branch_4();
        chk("ldbr_stall1", 1, 1, 0, 16'd1);
        clr(); MEM_Dest = 5'd4; MEM_WB_EN = 1'b1; MEM_MEM_R_EN = 1'b1;
        ID_Rs = 5'd4; ID_Rt = 5'd5; ID_two_src = 1'b1; ID_is_branch = 1'b1;
        chk("ldbr_stall2", 1, 1, 0, 16'd2);
        clr(); ID_Rs = 5'd4; ID_Rt = 5'd5; ID_two_src = 1'b1; ID_is_branch = 1'b1;
        chk("ldbr_release", 0, 0, 0, 16'd3);
        clr(); EXE_Dest = 5'd4; EXE_WB_EN = 1'b1;
        ID_Rs = 5'd4; ID_Rt = 5'd5; ID_two_src = 1'b1; ID_is_branch = 1'b1;
        chk("alubr_stall", 1, 1, 0, 16'd3);
        clr();
        chk("alubr_release", 0, 0, 0, 16'd4);

        // forwarding disabled
        clr(); fwd_EN = 1'b0; EXE_Dest = 5'd7; EXE_WB_EN = 1'b1;
        ID_Rs = 5'd2; ID_Rt = 5'd7; ID_two_src = 1'b1;
        chk("nofwd_exe_stall1", 1, 1, 0, 16'd4);
        clr(); fwd_EN = 1'b0;
        chk("nofwd_exe_stall2", 1, 1, 0, 16'd5);
        chk("nofwd_exe_release", 0, 0, 0, 16'd6);
        clr(); fwd_EN = 1'b0; EXE_Dest = 5'd7; EXE_WB_EN = 1'b1;
        ID_Rs = 5'd2; ID_Rt = 5'd7; ID_two_src = 1'b0;
        chk("nofwd_rt_unused", 0, 0, 0, 16'd6);
        clr(); fwd_EN = 1'b0; MEM_Dest = 5'd7; MEM_WB_EN = 1'b1; ID_Rs = 5'd7;
        chk("nofwd_mem_stall", 1, 1, 0, 16'd6);
        clr();
        chk("nofwd_mem_release", 0, 0, 0, 16'd7);

        // R0, non-writer, and MEM load feeding a non-branch
        clr(); EXE_Dest = 5'd0; EXE_WB_EN = 1'b1; EXE_MEM_R_EN = 1'b1;
        chk("r0_no_hazard", 0, 0, 0, 16'd7);
        clr(); EXE_Dest = 5'd8; EXE_MEM_R_EN = 1'b1; ID_Rs = 5'd8;
        chk("nonwriter_no_hazard", 0, 0, 0, 16'd7);
        clr(); MEM_Dest = 5'd8; MEM_WB_EN = 1'b1; MEM_MEM_R_EN = 1'b1; ID_Rs = 5'd8;
        chk("memload_alu_no_hazard", 0, 0, 0, 16'd7);

        // branch_taken aborts STALL
        load_branch_4();
        chk("abort_enter", 1, 1, 0, 16'd7);
        clr(); branch_taken = 1'b1;
        chk("abort_flush", 0, 1, 1, 16'd8);
        clr();
        chk("abort_idle", 0, 0, 0, 16'd8);
        load_branch_4(); branch_taken = 1'b1;
        chk("flush_beats_hazard", 0, 1, 1, 16'd8);
        clr();
        chk("flush_no_stall_entry", 0, 0, 0, 16'd8);

        // mem_stall freezes STALL
        load_branch_4();
        chk("memstall_enter", 1, 1, 0, 16'd8);
        clr(); mem_stall = 1'b1;
        chk("memstall_hold1", 1, 1, 0, 16'd9);
        chk("memstall_hold2", 1, 1, 0, 16'd9);
        chk("memstall_hold3", 1, 1, 0, 16'd9);
        mem_stall = 1'b0;
        chk("memstall_finish", 1, 1, 0, 16'd9);
        chk("memstall_release", 0, 0, 0, 16'd10);

        // reset mid-STALL drops the pending bubble
        load_branch_4();
        chk("rst_enter", 1, 1, 0, 16'd10);
        clr(); rst = 1'b1;
        chk("rst_mid_stall", 0, 0, 0, 16'd11);
        rst = 1'b0;
        chk("rst_discard", 0, 0, 0, 16'd0);

        // saturation: continuous load-use stall for more than 2^16 cycles
        load_use_8();
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_hold", 1, 1, 0, 16'hFFFF);
        clr();
        chk("sat_stays", 0, 0, 0, 16'hFFFF);

        @(posedge clk); #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
